// File: rtl/hazard_stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl_pkg
// Shared types and constants for the hazard stall controller.
//   REG_ADDR_W    : register-file address width
//   X0_ADDR       : hard-wired zero register; writes to it never create hazards
//   wr_tag_t      : destination tag {addr, sig} carried down EX/MEM/WB
//   BUBBLE_TAG    : tag of an inserted NOP (addr 0, no write)
//   stall_state_t : controller FSM states (RUN, STALL)
// ---------------------------------------------------------------------------
package hazard_stall_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] X0_ADDR = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic                  sig;
  } wr_tag_t;

  localparam wr_tag_t BUBBLE_TAG = '{addr: X0_ADDR, sig: 1'b0};

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } stall_state_t;

  // A write to x0 is architecturally a no-op, so it travels down the pipe
  // as a bubble and the detector never matches on it.
  function automatic wr_tag_t apply_x0(input logic [REG_ADDR_W-1:0] addr,
                                       input logic                  sig);
    wr_tag_t tag;
    if (addr == X0_ADDR) begin
      tag = BUBBLE_TAG;
    end else begin
      tag.addr = addr;
      tag.sig  = sig;
    end
    return tag;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl_if
// Bundle between the core pipeline (master) and the stall controller (slave).
//   master drives : id_reg_wr_addr_i, id_reg_wr_sig_i, hazard_detected_i, flush_i
//   slave drives  : EX/MEM/WB write tags, pc_hold_o, if_id_hold_o,
//                   if_id_flush_o, id_ex_bubble_o, stall_err_o, stall_cnt_o
// PERF_W sizes stall_cnt_o (only counts when HAZARD_STALL_PERF_EN is defined).
// ---------------------------------------------------------------------------
interface hazard_stall_ctrl_if #(
  parameter int PERF_W = 32
);
  import hazard_stall_ctrl_pkg::*;

  logic [REG_ADDR_W-1:0] id_reg_wr_addr_i;
  logic                  id_reg_wr_sig_i;
  logic                  hazard_detected_i;
  logic                  flush_i;

  logic [REG_ADDR_W-1:0] ex_reg_wr_addr_o;
  logic                  ex_reg_wr_sig_o;
  logic [REG_ADDR_W-1:0] mem_reg_wr_addr_o;
  logic                  mem_reg_wr_sig_o;
  logic [REG_ADDR_W-1:0] wb_reg_wr_addr_o;
  logic                  wb_reg_wr_sig_o;
  logic                  pc_hold_o;
  logic                  if_id_hold_o;
  logic                  if_id_flush_o;
  logic                  id_ex_bubble_o;
  logic                  stall_err_o;
  logic [PERF_W-1:0]     stall_cnt_o;

  modport master (
    output id_reg_wr_addr_i, id_reg_wr_sig_i, hazard_detected_i, flush_i,
    input  ex_reg_wr_addr_o, ex_reg_wr_sig_o, mem_reg_wr_addr_o, mem_reg_wr_sig_o,
           wb_reg_wr_addr_o, wb_reg_wr_sig_o, pc_hold_o, if_id_hold_o,
           if_id_flush_o, id_ex_bubble_o, stall_err_o, stall_cnt_o
  );

  modport slave (
    input  id_reg_wr_addr_i, id_reg_wr_sig_i, hazard_detected_i, flush_i,
    output ex_reg_wr_addr_o, ex_reg_wr_sig_o, mem_reg_wr_addr_o, mem_reg_wr_sig_o,
           wb_reg_wr_addr_o, wb_reg_wr_sig_o, pc_hold_o, if_id_hold_o,
           if_id_flush_o, id_ex_bubble_o, stall_err_o, stall_cnt_o
  );

endinterface

// File: rtl/hazard_stall_ctrl_wr_tag_pipe.sv
// ---------------------------------------------------------------------------
// wr_tag_pipe
// Three-stage destination-tag shift register (EX -> MEM -> WB) with bubble
// insertion at the EX entry.
//   clk, rst_n : clock, asynchronous active-low reset
//   bubble     : load BUBBLE_TAG into EX instead of id_tag
//   id_tag     : ID-stage tag, x0 rule already applied
//   ex_tag, mem_tag, wb_tag : registered stage tags
// ---------------------------------------------------------------------------
module wr_tag_pipe
  import hazard_stall_ctrl_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    bubble,
  input  wr_tag_t id_tag,
  output wr_tag_t ex_tag,
  output wr_tag_t mem_tag,
  output wr_tag_t wb_tag
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_tag  <= BUBBLE_TAG;
      mem_tag <= BUBBLE_TAG;
      wb_tag  <= BUBBLE_TAG;
    end else begin
      wb_tag  <= mem_tag;
      mem_tag <= ex_tag;
      ex_tag  <= bubble ? BUBBLE_TAG : id_tag;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
// Stall/bubble/flush control for IF/ID, destination-tag pipeline for the
// hazard detector, and a watchdog on consecutive stall cycles.
//   clk_i, rst_n_i : core clock, asynchronous active-low reset
//   bus (slave)    : ID tag + hazard/flush in; EX/MEM/WB tags, hold/flush/
//                    bubble controls, sticky stall_err_o, stall_cnt_o out
// Optional macro HAZARD_STALL_PERF_EN: builds a free-running PERF_W-bit count
// of stalled cycles on stall_cnt_o; otherwise stall_cnt_o is tied to 0.
// ---------------------------------------------------------------------------
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MAX_STALL = 3,
  parameter int SCNT_W    = 2,
  parameter int PERF_W    = 32
) (
  input logic              clk_i,
  input logic              rst_n_i,
  hazard_stall_ctrl_if.slave bus
);

  localparam logic [SCNT_W-1:0] CNT_MAX  = {SCNT_W{1'b1}};
  localparam logic [SCNT_W-1:0] CNT_TRIP = SCNT_W'(MAX_STALL);

  logic         stall;
  logic         bubble;
  wr_tag_t      id_tag;
  wr_tag_t      ex_tag;
  wr_tag_t      mem_tag;
  wr_tag_t      wb_tag;

  stall_state_t state;
  stall_state_t state_next;
  logic [SCNT_W-1:0] cnt;
  logic [SCNT_W-1:0] cnt_next;
  logic         err;
  logic         err_next;

  // Flush wins over hazard: the instruction being killed must not stall.
  assign stall  = bus.hazard_detected_i & ~bus.flush_i;
  assign bubble = bus.hazard_detected_i | bus.flush_i;
  assign id_tag = apply_x0(bus.id_reg_wr_addr_i, bus.id_reg_wr_sig_i);

  assign bus.if_id_flush_o  = bus.flush_i;
  assign bus.pc_hold_o      = stall;
  assign bus.if_id_hold_o   = stall;
  assign bus.id_ex_bubble_o = bubble;

  wr_tag_pipe u_tag_pipe (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .bubble  (bubble),
    .id_tag  (id_tag),
    .ex_tag  (ex_tag),
    .mem_tag (mem_tag),
    .wb_tag  (wb_tag)
  );

  assign bus.ex_reg_wr_addr_o  = ex_tag.addr;
  assign bus.ex_reg_wr_sig_o   = ex_tag.sig;
  assign bus.mem_reg_wr_addr_o = mem_tag.addr;
  assign bus.mem_reg_wr_sig_o  = mem_tag.sig;
  assign bus.wb_reg_wr_addr_o  = wb_tag.addr;
  assign bus.wb_reg_wr_sig_o   = wb_tag.sig;
  assign bus.stall_err_o       = err;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= RUN;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      err   <= err_next;
    end
  end

  // Three bubbles drain EX/MEM/WB, so a stall still asserted after
  // MAX_STALL cycles means the detector is stuck; the error is sticky.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    err_next   = err;
    case (state)
      RUN: begin
        if (stall) begin
          state_next = STALL;
          cnt_next   = SCNT_W'(1);
        end
      end
      STALL: begin
        if (stall) begin
          if (cnt != CNT_MAX) begin
            cnt_next = cnt + SCNT_W'(1);
          end
          if (cnt == CNT_TRIP) begin
            err_next = 1'b1;
          end
        end else begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
    endcase
  end

`ifdef HAZARD_STALL_PERF_EN
  logic [PERF_W-1:0] perf_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      perf_cnt <= '0;
    end else if (stall) begin
      perf_cnt <= perf_cnt + PERF_W'(1);
    end
  end

  assign bus.stall_cnt_o = perf_cnt;
`else
  assign bus.stall_cnt_o = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl
// Scoreboard bench for hazard_stall_ctrl. Directed scenarios followed by
// random traffic; expected values come from a cycle-level reference model.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

  localparam int MAX_STALL = 3;
  localparam int PERF_W    = 32;

  typedef struct {
    logic [4:0]  exAddr;
    logic        exSig;
    logic [4:0]  memAddr;
    logic        memSig;
    logic [4:0]  wbAddr;
    logic        wbSig;
    logic        pcHold;
    logic        ifIdHold;
    logic        ifIdFlush;
    logic        bubble;
    logic        err;
    logic [31:0] perf;
  } expect_t;

  logic clk_i;
  logic rst_n_i;

  int testCount = 0;
  int failCount = 0;

  expect_t expQ[$];

  // Reference model: tag at each stage as {addr, sig}, index 0 = EX
  logic [4:0]  modelAddr[3];
  logic        modelSig[3];
  int          runLen;
  logic        modelErr;
  logic [31:0] modelPerf;

  hazard_stall_ctrl_if #(.PERF_W(PERF_W)) bus ();

  hazard_stall_ctrl #(
    .MAX_STALL (MAX_STALL),
    .SCNT_W    (2),
    .PERF_W    (PERF_W)
  ) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      modelAddr[i] = 5'd0;
      modelSig[i]  = 1'b0;
    end
    runLen    = 0;
    modelErr  = 1'b0;
    modelPerf = 32'd0;
  endtask

  // Drives one cycle of inputs just after a rising edge, queues what the DUT
  // must show during that cycle, then advances the model across the next edge.
  task automatic applyStimulus(input logic [4:0] addr, input logic sig,
                               input logic haz, input logic fl);
    expect_t e;
    logic    stallNow;
    @(posedge clk_i);
    #1;
    bus.id_reg_wr_addr_i  = addr;
    bus.id_reg_wr_sig_i   = sig;
    bus.hazard_detected_i = haz;
    bus.flush_i           = fl;

    stallNow    = haz && !fl;
    e.exAddr    = modelAddr[0];
    e.exSig     = modelSig[0];
    e.memAddr   = modelAddr[1];
    e.memSig    = modelSig[1];
    e.wbAddr    = modelAddr[2];
    e.wbSig     = modelSig[2];
    e.pcHold    = stallNow;
    e.ifIdHold  = stallNow;
    e.ifIdFlush = fl;
    e.bubble    = haz || fl;
    e.err       = modelErr;
    e.perf      = modelPerf;
    expQ.push_back(e);

    modelAddr[2] = modelAddr[1];
    modelSig[2]  = modelSig[1];
    modelAddr[1] = modelAddr[0];
    modelSig[1]  = modelSig[0];
    if (haz || fl || addr == 5'd0) begin
      modelAddr[0] = 5'd0;
      modelSig[0]  = 1'b0;
    end else begin
      modelAddr[0] = addr;
      modelSig[0]  = sig;
    end
    runLen = stallNow ? runLen + 1 : 0;
    if (runLen > MAX_STALL) modelErr = 1'b1;
    if (stallNow) modelPerf = modelPerf + 32'd1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ex_addr"},  32'(bus.ex_reg_wr_addr_o), 32'd0);
    checkOutput({tag, "_ex_sig"},   32'(bus.ex_reg_wr_sig_o), 32'd0);
    checkOutput({tag, "_mem_addr"}, 32'(bus.mem_reg_wr_addr_o), 32'd0);
    checkOutput({tag, "_mem_sig"},  32'(bus.mem_reg_wr_sig_o), 32'd0);
    checkOutput({tag, "_wb_addr"},  32'(bus.wb_reg_wr_addr_o), 32'd0);
    checkOutput({tag, "_wb_sig"},   32'(bus.wb_reg_wr_sig_o), 32'd0);
    checkOutput({tag, "_err"},      32'(bus.stall_err_o), 32'd0);
    checkOutput({tag, "_perf"},     32'(bus.stall_cnt_o), 32'd0);
  endtask

  task automatic resetDut();
    @(negedge clk_i);
    #1;
    rst_n_i               = 1'b0;
    bus.id_reg_wr_addr_i  = 5'd0;
    bus.id_reg_wr_sig_i   = 1'b0;
    bus.hazard_detected_i = 1'b0;
    bus.flush_i           = 1'b0;
    expQ.delete();
    modelReset();
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  // Monitor: every cycle the DUT presents its outputs, pop and compare.
  initial begin
    expect_t e;
    forever begin
      @(negedge clk_i);
      if (rst_n_i && expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("ex_addr",     32'(bus.ex_reg_wr_addr_o), 32'(e.exAddr));
        checkOutput("ex_sig",      32'(bus.ex_reg_wr_sig_o), 32'(e.exSig));
        checkOutput("mem_addr",    32'(bus.mem_reg_wr_addr_o), 32'(e.memAddr));
        checkOutput("mem_sig",     32'(bus.mem_reg_wr_sig_o), 32'(e.memSig));
        checkOutput("wb_addr",     32'(bus.wb_reg_wr_addr_o), 32'(e.wbAddr));
        checkOutput("wb_sig",      32'(bus.wb_reg_wr_sig_o), 32'(e.wbSig));
        checkOutput("pc_hold",     32'(bus.pc_hold_o), 32'(e.pcHold));
        checkOutput("if_id_hold",  32'(bus.if_id_hold_o), 32'(e.ifIdHold));
        checkOutput("if_id_flush", 32'(bus.if_id_flush_o), 32'(e.ifIdFlush));
        checkOutput("bubble",      32'(bus.id_ex_bubble_o), 32'(e.bubble));
        checkOutput("stall_err",   32'(bus.stall_err_o), 32'(e.err));
`ifdef HAZARD_STALL_PERF_EN
        checkOutput("stall_cnt",   32'(bus.stall_cnt_o), e.perf);
`else
        checkOutput("stall_cnt",   32'(bus.stall_cnt_o), 32'd0);
`endif
      end
    end
  end

  initial begin
    rst_n_i               = 1'b0;
    bus.id_reg_wr_addr_i  = 5'd0;
    bus.id_reg_wr_sig_i   = 1'b0;
    bus.hazard_detected_i = 1'b0;
    bus.flush_i           = 1'b0;
    modelReset();
    #12;
    checkResetState("reset");
    @(negedge clk_i);
    rst_n_i = 1'b1;

    $display("[TB] tag propagation and x0 rule");
    repeat (3) applyStimulus(5'd5, 1'b1, 1'b0, 1'b0);
    applyStimulus(5'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(5'd9, 1'b0, 1'b0, 1'b0);
    repeat (3) applyStimulus(5'd0, 1'b0, 1'b0, 1'b0);

    $display("[TB] three-cycle stall, no watchdog");
    repeat (3) applyStimulus(5'd7, 1'b1, 1'b1, 1'b0);
    repeat (4) applyStimulus(5'd7, 1'b1, 1'b0, 1'b0);

    $display("[TB] flush together with hazard");
    applyStimulus(5'd3, 1'b1, 1'b1, 1'b1);
    repeat (3) applyStimulus(5'd3, 1'b1, 1'b1, 1'b0);
    applyStimulus(5'd4, 1'b1, 1'b0, 1'b0);
    applyStimulus(5'd4, 1'b1, 1'b1, 1'b0);
    applyStimulus(5'd4, 1'b1, 1'b1, 1'b1);
    applyStimulus(5'd4, 1'b1, 1'b0, 1'b0);

    $display("[TB] two stalls of two cycles");
    resetDut();
    repeat (2) applyStimulus(5'd11, 1'b1, 1'b1, 1'b0);
    applyStimulus(5'd11, 1'b1, 1'b0, 1'b0);
    repeat (2) applyStimulus(5'd12, 1'b1, 1'b1, 1'b0);
    repeat (2) applyStimulus(5'd12, 1'b1, 1'b0, 1'b0);
    @(negedge clk_i);
    #1;
`ifdef HAZARD_STALL_PERF_EN
    checkOutput("perf_two_stalls", 32'(bus.stall_cnt_o), 32'd4);
`else
    checkOutput("perf_tied_zero", 32'(bus.stall_cnt_o), 32'd0);
`endif

    $display("[TB] watchdog trip and sticky error");
    resetDut();
    repeat (5) applyStimulus(5'd13, 1'b1, 1'b1, 1'b0);
    repeat (3) applyStimulus(5'd14, 1'b1, 1'b0, 1'b0);
    @(negedge clk_i);
    #1;
    checkOutput("err_sticky", 32'(bus.stall_err_o), 32'd1);
    resetDut();
    #1;
    checkOutput("err_cleared", 32'(bus.stall_err_o), 32'd0);

    $display("[TB] asynchronous reset mid-stall");
    repeat (2) applyStimulus(5'd15, 1'b1, 1'b0, 1'b0);
    repeat (2) applyStimulus(5'd16, 1'b1, 1'b1, 1'b0);
    @(negedge clk_i);
    #2;
    rst_n_i = 1'b0;
    #1;
    checkResetState("async_reset");
    bus.hazard_detected_i = 1'b0;
    #1;
    checkOutput("async_reset_hold", 32'(bus.pc_hold_o), 32'd0);
    resetDut();

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
    end

    @(negedge clk_i);
    #1;
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Partner of the decode stage's hazard detection unit: it consumes `hazard_detected` and the decoded destination, and produces the EX/MEM/WB write-back address/valid tags that the detector compares against.
- Owns the destination-tag pipeline, stall/bubble/flush control for IF/ID, and a stall watchdog.
- Sits beside the pipeline registers in the core top, one instance per core.

Parameters:
- MAX_STALL, 3, consecutive stall cycles allowed before stall_err_o is raised.
- SCNT_W, 2, width of the consecutive-stall counter (must hold MAX_STALL).
- PERF_W, 32, width of the optional stall performance counter.

Ports:
- clk_i  in  1  core clock
- rst_n_i  in  1  asynchronous active-low reset
- id_reg_wr_addr_i  in  5  destination register decoded in ID
- id_reg_wr_sig_i  in  1  ID instruction writes a register
- hazard_detected_i  in  1  RAW hazard flag from the decode stage
- flush_i  in  1  branch taken, resolved in EX; kill IF/ID contents
- ex_reg_wr_addr_o  out  5  destination tag, EX stage
- ex_reg_wr_sig_o  out  1  write valid, EX stage
- mem_reg_wr_addr_o  out  5  destination tag, MEM stage
- mem_reg_wr_sig_o  out  1  write valid, MEM stage
- wb_reg_wr_addr_o  out  5  destination tag, WB stage
- wb_reg_wr_sig_o  out  1  write valid, WB stage
- pc_hold_o  out  1  freeze PC
- if_id_hold_o  out  1  freeze IF/ID register
- if_id_flush_o  out  1  clear IF/ID register
- id_ex_bubble_o  out  1  load NOP into ID/EX
- stall_err_o  out  1  sticky watchdog error
- stall_cnt_o  out  PERF_W  total stall cycles (only with feature)

Behaviour:
- Clocking and reset: one clock, clk_i; reset is asynchronous and active-low on rst_n_i.
  - On reset, all tag addresses are 0, all write-valids are 0, stall counter is 0, stall_err_o is 0, FSM is RUN.
- Combinational control, same cycle, no latency:
  - if_id_flush_o = flush_i.
  - pc_hold_o = if_id_hold_o = hazard_detected_i & ~flush_i.
  - id_ex_bubble_o = hazard_detected_i | flush_i.
  - Flush has priority over hazard: a killed instruction must not stall.
- x0 rule: an ID entry with addr==0 enters EX with sig=0 and addr=0, so x0 writes never create hazards.
- Tag shift, every rising edge:
  - WB <= MEM, and MEM <= EX.
  - EX <= bubble (addr 0, sig 0) if id_ex_bubble_o, else the ID entry after the x0 rule.
  - Outputs are registered; the 1-cycle latency ID -> EX tag matches the ID/EX pipeline register.
- FSM with states RUN and STALL:
  - RUN -> STALL when hazard_detected_i & ~flush_i; the counter loads 1.
  - STALL stays in STALL while the hazard persists; the counter increments and saturates at its maximum.
  - STALL -> RUN when the hazard drops or flush_i is asserted; the counter clears.
- Watchdog: if in STALL, the counter == MAX_STALL and the hazard is still asserted, set stall_err_o.
  - stall_err_o is sticky until reset.
  - Three bubbles drain EX/MEM/WB, so a correct detector always releases within MAX_STALL.
- Boundary cases:
  - flush_i together with a hazard: bubble, no hold, FSM -> RUN.
  - Reset mid-stall: everything returns to reset values immediately, because reset is asynchronous.
  - Hazard deasserting in the same cycle as the counter reaching MAX_STALL: no error.

Optional Feature:
- Macro HAZARD_STALL_PERF_EN.
- Defined: stall_cnt_o is a free-running PERF_W-bit counter.
  - Increments on every cycle with pc_hold_o=1.
  - Wraps modulo 2^PERF_W.
  - Resets to 0.
- Undefined: the counter is not built and stall_cnt_o is tied to 0; the port is kept so the core top is unchanged.

Decomposition:
- Shared package holds:
  - REG_ADDR_W=5 and the X0_ADDR constant.
  - The bubble tag constant {addr 0, sig 0}.
  - The FSM state typedef (RUN, STALL).
- One natural sub-module: wr_tag_pipe, the 3-stage tag shift register with bubble insert.
- FSM, watchdog and optional counter stay in the top.

Test Plan:
- Reset, then ID addr=5 sig=1 with no hazard for 3 cycles -> tag appears at EX in cycle 1, MEM in cycle 2, WB in cycle 3; addr 5, sig 1 at each.
- ID addr=0 sig=1 -> ex_reg_wr_sig_o=0 next cycle, ex_reg_wr_addr_o=0.
- hazard_detected_i=1 for 3 cycles, then 0 -> pc_hold_o/if_id_hold_o high for exactly 3 cycles; 3 bubbles appear in EX; stall_err_o stays 0.
- hazard_detected_i=1 and flush_i=1 in the same cycle -> pc_hold_o=0, if_id_flush_o=1, id_ex_bubble_o=1, FSM in RUN.
- hazard_detected_i held for 5 cycles with MAX_STALL=3 -> stall_err_o rises on cycle 4 and stays high until rst_n_i is asserted low.
- With HAZARD_STALL_PERF_EN: 2 stalls of 2 cycles each -> stall_cnt_o=4.
  - Assert rst_n_i low asynchronously mid-stall -> all outputs 0 without a clock edge.
